// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered adder among NREQ requesters.
// A grant in IDLE is followed by one ISSUE cycle (add_en) and one CAPTURE cycle, then a done strobe.
module adder_share_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned IDW       = 2,
  parameter int unsigned Abitwidth = 21,
  parameter int unsigned Bbitwidth = 21,
  parameter int unsigned Sbitwidth = 22
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*Abitwidth-1:0] req_a,
  input  logic [NREQ*Bbitwidth-1:0] req_b,
  output logic [NREQ-1:0]           done,
  output logic [Sbitwidth-1:0]      result,
  output logic [IDW-1:0]            result_id,
  output logic                      busy,
  output logic                      add_en,
  output logic [Abitwidth-1:0]      add_a,
  output logic [Bbitwidth-1:0]      add_b,
  input  logic [Sbitwidth-1:0]      add_sum
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, grant_id, win;
  logic            found;
  logic [NREQ-1:0] elig;

  // The requester strobed this cycle is excluded so it cannot be re-granted immediately.
  assign elig   = req & ~done;
  assign busy   = (state != IDLE);
  assign add_en = (state == ISSUE);

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      grant_id  <= '0;
      add_a     <= '0;
      add_b     <= '0;
      done      <= '0;
      result    <= '0;
      result_id <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_id <= win;
            add_a    <= req_a[32'(win)*Abitwidth +: Abitwidth];
            add_b    <= req_b[32'(win)*Bbitwidth +: Bbitwidth];
          end
        end
        CAPTURE: begin
          result         <= add_sum;
          result_id      <= grant_id;
          done[grant_id] <= 1'b1;
          ptr            <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: transaction-level round-robin model plus directed literal cases
// and randomized requester traffic; a behavioural registered adder stands in for the shared unit.
module tb_adder_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int AW   = 21;
  localparam int BW   = 21;
  localparam int SW   = 22;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_a;
  logic [NREQ*BW-1:0]   req_b;
  logic [NREQ-1:0]      done;
  logic [SW-1:0]        result;
  logic [IDW-1:0]       result_id;
  logic                 busy, add_en;
  logic [AW-1:0]        add_a;
  logic [BW-1:0]        add_b;
  logic [SW-1:0]        add_sum = '0;

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .Abitwidth(AW), .Bbitwidth(BW), .Sbitwidth(SW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .done(done), .result(result), .result_id(result_id), .busy(busy),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
  );

  always #5 clock = ~clock;

  // Shared adder: registered sum, updated only when enabled.
  always @(posedge clock) if (add_en) add_sum <= SW'(add_a) + SW'(add_b);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: an operation is "in flight" for m_since = 0 (issuing) and 1 (capturing); -1 = free.
  int              m_ptr = 0, m_id = 0, m_since = -1;
  logic [AW-1:0]   m_a = '0;
  logic [BW-1:0]   m_b = '0;
  logic [NREQ-1:0] m_done = '0;
  logic [SW-1:0]   m_result = '0;
  int              m_rid = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    logic [NREQ-1:0] elig;
    int w;
    if (reset) begin
      m_ptr = 0; m_id = 0; m_since = -1; m_a = '0; m_b = '0;
      m_done = '0; m_result = '0; m_rid = 0;
      return;
    end
    elig   = req & ~m_done;
    m_done = '0;
    if (m_since == 1) begin
      m_result       = SW'(m_a) + SW'(m_b);
      m_rid          = m_id;
      m_done[m_id]   = 1'b1;
      m_ptr          = (m_id + 1) % NREQ;
      m_since        = -1;
    end else if (m_since == 0) begin
      m_since = 1;
    end else begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      if (w >= 0) begin
        m_id    = w;
        m_a     = req_a[w*AW +: AW];
        m_b     = req_b[w*BW +: BW];
        m_since = 0;
      end
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare outputs.
  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    cyc++;
    chk("done",      64'(done),      64'(m_done));
    chk("result",    64'(result),    64'(m_result));
    chk("result_id", 64'(result_id), 64'(m_rid));
    chk("busy",      64'(busy),      64'(m_since >= 0));
    chk("add_en",    64'(add_en),    64'(m_since == 0));
    chk("add_a",     64'(add_a),     64'(m_a));
    chk("add_b",     64'(add_b),     64'(m_b));
  endtask

  task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    req_a[i*AW +: AW] = a;
    req_b[i*BW +: BW] = b;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_a = '0; req_b = '0;
    step(); step();
    chk("rst_outputs", 64'({done, result, result_id, busy, add_en, add_a, add_b}), 64'd0);
    reset = 1'b0;
    step();

    // Single request on requester 2.
    set_op(2, 21'd5, 21'd7); req = 4'b0100;
    step();
    chk("t1_add_en", 64'(add_en), 64'd1);
    chk("t1_add_a",  64'(add_a),  64'd5);
    chk("t1_add_b",  64'(add_b),  64'd7);
    step();
    chk("t1_busy", 64'(busy), 64'd1);
    step();
    chk("t1_done",   64'(done),      64'b0100);
    chk("t1_result", 64'(result),    64'd12);
    chk("t1_rid",    64'(result_id), 64'd2);
    chk("t1_busy3",  64'(busy),      64'd0);
    req = '0;
    step();

    // Wrap-around: pointer sits at 3, so 3 goes before 0.
    set_op(3, 21'd100, 21'd1); set_op(0, 21'd200, 21'd2); req = 4'b1001;
    step(); step(); step();
    chk("wrap_done1", 64'(done),   64'b1000);
    chk("wrap_res1",  64'(result), 64'd101);
    req[3] = 1'b0;
    step(); step(); step();
    chk("wrap_done2", 64'(done),   64'b0001);
    chk("wrap_res2",  64'(result), 64'd202);
    req = '0;
    step();

    // Full-scale operands must not truncate.
    set_op(0, '1, '1); req = 4'b0001;
    step(); step(); step();
    chk("full_res", 64'(result), 64'h3FFFFE);
    req = '0;
    step();

    // All four requesting from reset, operands i and 10*i.
    reset = 1'b1; step(); step(); reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, AW'(i), BW'(10*i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(); step(); step();
      chk("all_done", 64'(done),      64'(4'b0001 << (k % 4)));
      chk("all_res",  64'(result),    64'(11 * (k % 4)));
      chk("all_rid",  64'(result_id), 64'(k % 4));
    end

    // Requesters 1 and 3 held high: they alternate.
    set_op(1, 21'd1, 21'd1); set_op(3, 21'd3, 21'd3); req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step(); step(); step();
      chk("held_rid", 64'(result_id), (k % 2 == 0) ? 64'd1 : 64'd3);
    end
    req = '0;
    step();

    // Reset during CAPTURE discards the operation; the held request then completes afresh.
    set_op(1, 21'd3, 21'd4); req = 4'b0010;
    step(); step();
    chk("rc_busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    chk("rc_outputs", 64'({done, result, result_id, busy, add_en, add_a, add_b}), 64'd0);
    reset = 1'b0;
    step();
    chk("rc_add_en", 64'(add_en), 64'd1);
    step(); step();
    chk("rc_done", 64'(done),   64'b0010);
    chk("rc_res",  64'(result), 64'd7);
    req = '0;
    step();

    // Randomized requester traffic obeying the handshake protocol.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            set_op(i, AW'($urandom()), BW'($urandom()));
            req[i] = 1'b1;
          end
        end else if (m_done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else set_op(i, AW'($urandom()), BW'($urandom()));
        end else if (!(m_since >= 0 && m_id == i) && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      step();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
